// File: rtl/sem_waiter_pkg.sv
// Shared types for the blocking-semaphore front end: rq/status codes, FSM states, request payload.
// Also holds the 8-bit jitter LFSR step function.
package sem_waiter_pkg;

    localparam int unsigned SEM_W    = 6;
    localparam int unsigned RQ_W     = 32;
    localparam int unsigned CORE_W   = 4;
    localparam int unsigned STATUS_W = 2;
    localparam int unsigned LFSR_W   = 8;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned WIN_W    = CNT_W + 1;

    localparam logic [LFSR_W-CORE_W-1:0] LFSR_SEED_HI = 4'hA;

    // Semaphore unit rq codes; SEM_VDONE extends them into the response status space.
    typedef enum logic [STATUS_W-1:0] {
        SEM_FAIL  = 2'd0,
        SEM_GOT   = 2'd1,
        SEM_HELD  = 2'd2,
        SEM_VDONE = 2'd3
    } sem_code_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BACKOFF = 2'd2,
        ST_RESP    = 2'd3
    } sem_state_e;

    typedef struct packed {
        logic [SEM_W-1:0] sem;
        logic             is_p;
    } sem_req_t;

    // Fibonacci step, taps x^8+x^6+x^5+x^4+1.
    function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

endpackage

// File: rtl/sem_waiter_lfsr8.sv
// 8-bit Fibonacci LFSR with loadable seed; shared by blocks that need backoff jitter.
module lfsr8
    import sem_waiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step_en,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] value_q;
    logic [LFSR_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (step_en) begin
            value_d = lfsr8_next(value_q);
        end
    end

    // Seed must be non-zero; the all-zero state is a lock-up state.
    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/sem_waiter.sv
// Blocking P/V front end for one core: drives the semaphore unit handshake and
// retries failed P operations after a jittered exponential backoff.
module sem_waiter
    import sem_waiter_pkg::*;
#(
    parameter int unsigned BACKOFF_MIN = 8,
    parameter int unsigned BACKOFF_MAX = 1024,
    parameter int unsigned MAX_TRIES   = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CORE_W-1:0]   whichCore,
    input  logic                reqValid,
    output logic                reqReady,
    input  logic [SEM_W-1:0]    reqSem,
    input  logic                reqWait,
    input  logic                abort,
    output logic                respValid,
    output logic [STATUS_W-1:0] respStatus,
    output logic                semSel,
    output logic [SEM_W-1:0]    semAq,
    output logic                semRead,
    input  logic [RQ_W-1:0]     semRq,
    input  logic                semWrq,
    input  logic                semDone,
    output logic                waiting
);

    sem_state_e       state_q, state_d;
    sem_req_t         req_q, req_d;
    logic [CNT_W-1:0] tries_q, tries_d;
    logic [CNT_W-1:0] window_q, window_d;
    logic [CNT_W-1:0] backoff_q, backoff_d;
    sem_code_e        status_q, status_d;
    logic             resp_valid_q, resp_valid_d;
    logic             sem_sel_q, sem_sel_d;
    logic             req_ready_q, req_ready_d;
    logic             waiting_q, waiting_d;

    logic [LFSR_W-1:0] lfsr_value;
    sem_code_e         rq_code;
    logic              rq_success;
    logic              give_up;
    logic [CNT_W-1:0]  tries_inc;
    logic [LFSR_W-1:0] jitter_mask;
    logic [CNT_W-1:0]  backoff_load;
    logic [WIN_W-1:0]  window_dbl;
    logic [CNT_W-1:0]  window_next;
    logic              unused_rq_hi;

    lfsr8 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .seed    ({LFSR_SEED_HI, whichCore}),
        .step_en (1'b1),
        .value   (lfsr_value)
    );

    assign rq_code      = sem_code_e'(semRq[1:0]);
    assign unused_rq_hi = ^semRq[RQ_W-1:2];
    assign rq_success   = semWrq && (rq_code == SEM_GOT || rq_code == SEM_HELD);

    // tries saturates instead of wrapping so an unlimited P never spuriously hits a limit.
    assign tries_inc = (tries_q == '1) ? tries_q : tries_q + CNT_W'(1);
    assign give_up   = (MAX_TRIES != 0) && (tries_inc == CNT_W'(MAX_TRIES));

    // Jitter is bounded by the window and by the LFSR's 8 bits.
    assign jitter_mask  = LFSR_W'(window_q - CNT_W'(1));
    assign backoff_load = window_q + CNT_W'(lfsr_value & jitter_mask);

    assign window_dbl  = {window_q, 1'b0};
    assign window_next = (window_dbl > WIN_W'(BACKOFF_MAX)) ? CNT_W'(BACKOFF_MAX)
                                                            : CNT_W'(window_dbl);

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        tries_d      = tries_q;
        window_d     = window_q;
        backoff_d    = backoff_q;
        status_d     = status_q;
        req_ready_d  = 1'b0;
        sem_sel_d    = 1'b0;
        waiting_d    = 1'b0;
        resp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (reqValid && req_ready_q) begin
                    req_d.sem  = reqSem;
                    req_d.is_p = reqWait;
                    tries_d    = '0;
                    window_d   = CNT_W'(BACKOFF_MIN);
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (semDone) begin
                    if (!req_q.is_p) begin
                        status_d = SEM_VDONE;
                        state_d  = ST_RESP;
                    end else if (rq_success) begin
                        status_d = rq_code;
                        state_d  = ST_RESP;
                    end else begin
                        // Anything other than a confirmed acquire is retried like a ring failure.
                        tries_d = tries_inc;
                        if (give_up) begin
                            status_d = SEM_FAIL;
                            state_d  = ST_RESP;
                        end else begin
                            backoff_d = backoff_load;
                            window_d  = window_next;
                            state_d   = ST_BACKOFF;
                        end
                    end
                end
            end
            ST_BACKOFF: begin
                if (abort) begin
                    status_d = SEM_FAIL;
                    state_d  = ST_RESP;
                end else if (backoff_q <= CNT_W'(1)) begin
                    state_d = ST_ISSUE;
                end else begin
                    backoff_d = backoff_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        req_ready_d  = (state_d == ST_IDLE);
        sem_sel_d    = (state_d == ST_ISSUE);
        waiting_d    = (state_d == ST_BACKOFF);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            tries_q      <= '0;
            window_q     <= CNT_W'(BACKOFF_MIN);
            backoff_q    <= '0;
            status_q     <= SEM_FAIL;
            resp_valid_q <= 1'b0;
            sem_sel_q    <= 1'b0;
            req_ready_q  <= 1'b0;
            waiting_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            tries_q      <= tries_d;
            window_q     <= window_d;
            backoff_q    <= backoff_d;
            status_q     <= status_d;
            resp_valid_q <= resp_valid_d;
            sem_sel_q    <= sem_sel_d;
            req_ready_q  <= req_ready_d;
            waiting_q    <= waiting_d;
        end
    end

    assign reqReady   = req_ready_q;
    assign respValid  = resp_valid_q;
    assign respStatus = status_q;
    assign semSel     = sem_sel_q;
    assign semAq      = req_q.sem;
    assign semRead    = req_q.is_p;
    assign waiting    = waiting_q;

endmodule

// File: tb/tb_sem_waiter.sv
// Directed + randomized bench for sem_waiter with a behavioural semaphore unit model.
module tb_sem_waiter;

    logic        clock;
    logic        reset;
    logic [3:0]  whichCore;
    logic        reqValid;
    logic [5:0]  reqSem;
    logic        reqWait;
    logic        abort;
    logic [31:0] semRq;
    logic        semWrq;
    logic        semDone;

    logic        reqReady, respValid, semSel, semRead, waiting;
    logic [1:0]  respStatus;
    logic [5:0]  semAq;
    logic        g_reqReady, g_respValid, g_semSel, g_semRead, g_waiting;
    logic [1:0]  g_respStatus;
    logic [5:0]  g_semAq;

    int total;
    int bad;

    // Semaphore unit model: done after mdl_lat extra cycles of select; first mdl_fails P's fail.
    int         mdl_lat;
    int         mdl_fails;
    logic [1:0] mdl_res;
    int         ep_cnt;
    int         fails_seen;
    logic [1:0] rq2;

    // Transaction observations
    int t_got, t_status, t_eps, t_sel_cycles, t_aq_err, t_resp_lat;
    int gaps[$];

    sem_waiter #(.BACKOFF_MIN(8), .BACKOFF_MAX(1024), .MAX_TRIES(0)) dut (
        .clock(clock), .reset(reset), .whichCore(whichCore),
        .reqValid(reqValid), .reqReady(reqReady), .reqSem(reqSem), .reqWait(reqWait),
        .abort(abort), .respValid(respValid), .respStatus(respStatus),
        .semSel(semSel), .semAq(semAq), .semRead(semRead),
        .semRq(semRq), .semWrq(semWrq), .semDone(semDone), .waiting(waiting)
    );

    sem_waiter #(.BACKOFF_MIN(8), .BACKOFF_MAX(1024), .MAX_TRIES(2)) dut_g (
        .clock(clock), .reset(reset), .whichCore(whichCore),
        .reqValid(reqValid), .reqReady(g_reqReady), .reqSem(reqSem), .reqWait(reqWait),
        .abort(abort), .respValid(g_respValid), .respStatus(g_respStatus),
        .semSel(g_semSel), .semAq(g_semAq), .semRead(g_semRead),
        .semRq(semRq), .semWrq(semWrq), .semDone(semDone), .waiting(g_waiting)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign rq2     = (semRead && fails_seen < mdl_fails) ? 2'b00 : mdl_res;
    assign semRq   = {30'b0, rq2};
    assign semWrq  = (rq2 != 2'b00);
    assign semDone = semSel && (ep_cnt == mdl_lat);

    always @(posedge clock) begin
        if (reset) begin
            ep_cnt     <= 0;
            fails_seen <= 0;
        end else begin
            ep_cnt <= semSel ? ep_cnt + 1 : 0;
            if (reqValid && reqReady)
                fails_seen <= 0;
            else if (semDone && semRead && rq2 == 2'b00)
                fails_seen <= fails_seen + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] core);
        whichCore = core;
        reqValid  = 1'b0;
        abort     = 1'b0;
        reset     = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic issue_req(input logic [5:0] sem, input logic isp);
        int waited;
        waited = 0;
        while (reqReady !== 1'b1 && waited < 50) begin
            cyc();
            waited++;
        end
        reqSem   = sem;
        reqWait  = isp;
        reqValid = 1'b1;
        cyc();
        reqValid = 1'b0;
    endtask

    task automatic run_txn(input logic [5:0] sem, input logic isp, input int lat,
                           input int fails, input logic [1:0] res);
        int   run;
        logic prev_sel;
        mdl_lat   = lat;
        mdl_fails = fails;
        mdl_res   = res;
        t_got = 0; t_status = -1; t_eps = 0; t_sel_cycles = 0; t_aq_err = 0; t_resp_lat = -1;
        gaps.delete();
        run      = 0;
        prev_sel = 1'b0;
        issue_req(sem, isp);
        for (int c = 0; c < 5000 && t_got == 0; c++) begin
            if (semSel === 1'b1) begin
                t_sel_cycles++;
                if (!prev_sel) t_eps++;
                if (semAq !== sem || semRead !== isp) t_aq_err++;
            end
            prev_sel = semSel;
            if (waiting === 1'b1) begin
                run++;
                if (semSel !== 1'b0) t_aq_err++;
            end else if (run > 0) begin
                gaps.push_back(run);
                run = 0;
            end
            if (respValid === 1'b1) begin
                t_got      = 1;
                t_status   = int'(respStatus);
                t_resp_lat = c;
            end else begin
                cyc();
            end
        end
    endtask

    initial begin
        int lat, sum, cnt, found;
        logic [5:0] s;
        logic       p;
        logic [1:0] r;
        int         f;

        total = 0; bad = 0;
        reqValid = 0; reqSem = 0; reqWait = 0; abort = 0;
        mdl_lat = 0; mdl_fails = 0; mdl_res = 2'd1;
        whichCore = 4'd3;
        reset = 1'b1;
        repeat (3) cyc();
        chk("rst_reqReady", reqReady, 0);
        chk("rst_respValid", respValid, 0);
        chk("rst_respStatus", respStatus, 0);
        chk("rst_semSel", semSel, 0);
        chk("rst_semAq", semAq, 0);
        chk("rst_semRead", semRead, 0);
        chk("rst_waiting", waiting, 0);
        chk("rst_g_outputs", {g_reqReady, g_respValid, g_respStatus, g_semSel, g_semAq, g_semRead, g_waiting}, 0);
        reset = 1'b0;
        cyc();
        chk("post_rst_reqReady", reqReady, 1);

        // Local hold: done combinational in the first ISSUE cycle.
        run_txn(6'd5, 1'b1, 0, 0, 2'd2);
        chk("hold_got", t_got, 1);
        chk("hold_status", t_status, 2);
        chk("hold_latency", t_resp_lat, 1);
        chk("hold_sel_cycles", t_sel_cycles, 1);
        chk("hold_aq", t_aq_err, 0);
        cyc();
        chk("hold_resp_one_cycle", respValid, 0);
        chk("hold_ready_back", reqReady, 1);

        // Ring acquire with a 9-cycle unit latency.
        run_txn(6'd12, 1'b1, 9, 0, 2'd1);
        chk("ring_status", t_status, 1);
        chk("ring_sel_cycles", t_sel_cycles, 10);
        chk("ring_latency", t_resp_lat, 10);
        chk("ring_aq_stable", t_aq_err, 0);

        // Retry/backoff: three failures, windows double each time.
        for (int k = 0; k < 3; k++) begin
            do_reset((k == 0) ? 4'd3 : 4'($urandom_range(0, 15)));
            lat = $urandom_range(0, 3);
            run_txn(6'($urandom_range(0, 63)), 1'b1, lat, 3, 2'd1);
            chk("retry_status", t_status, 1);
            chk("retry_episodes", t_eps, 4);
            chk("retry_gap_count", gaps.size(), 3);
            sum = 0;
            for (int i = 0; i < gaps.size() && i < 3; i++) begin
                chk("retry_gap_in_window", (gaps[i] >= (8 << i)) && (gaps[i] <= (16 << i) - 1), 1);
                sum += gaps[i];
            end
            chk("retry_latency", t_resp_lat, 4 * (lat + 1) + sum);
            chk("retry_no_sel_in_backoff", t_aq_err, 0);
        end

        // Give-up with MAX_TRIES = 2 (second instance).
        do_reset(4'($urandom_range(0, 15)));
        mdl_lat = $urandom_range(0, 2); mdl_fails = 1000; mdl_res = 2'd1;
        issue_req(6'd7, 1'b1);
        cnt = 0; found = 0;
        begin
            logic prev;
            prev = 1'b0;
            for (int c = 0; c < 500 && found == 0; c++) begin
                if (g_semSel === 1'b1 && !prev) cnt++;
                prev = g_semSel;
                if (g_respValid === 1'b1) found = 1; else cyc();
            end
        end
        chk("giveup_resp", found, 1);
        chk("giveup_episodes", cnt, 2);
        chk("giveup_status", g_respStatus, 0);
        cnt = 0;
        repeat (40) begin
            cyc();
            if (g_semSel === 1'b1) cnt++;
        end
        chk("giveup_no_more_sel", cnt, 0);

        // Abort in cycle 3 of a backoff.
        do_reset(4'($urandom_range(0, 15)));
        mdl_lat = 0; mdl_fails = 1000; mdl_res = 2'd1;
        issue_req(6'd9, 1'b1);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (waiting === 1'b1) found = 1; else cyc();
        end
        chk("abort_reach_backoff", found, 1);
        cyc();
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_respValid", respValid, 1);
        chk("abort_status", respStatus, 0);
        chk("abort_semSel", semSel, 0);
        cnt = 0;
        repeat (30) begin
            cyc();
            if (semSel === 1'b1) cnt++;
        end
        chk("abort_no_more_sel", cnt, 0);
        chk("abort_ready_back", reqReady, 1);

        // Abort held during ISSUE is ignored.
        mdl_lat = 6; mdl_fails = 0; mdl_res = 2'd1;
        issue_req(6'd20, 1'b1);
        abort = 1'b1;
        repeat (3) cyc();
        abort = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            if (respValid === 1'b1) found = 1; else cyc();
        end
        chk("issue_abort_resp", found, 1);
        chk("issue_abort_status", respStatus, 1);

        // V on sem 63.
        run_txn(6'd63, 1'b0, $urandom_range(0, 4), 0, 2'd1);
        chk("v_status", t_status, 3);
        chk("v_aq_read", t_aq_err, 0);
        chk("v_episodes", t_eps, 1);

        // Randomized mix against the model's expected outcome.
        for (int k = 0; k < 8; k++) begin
            s = 6'($urandom_range(0, 63));
            p = 1'($urandom_range(0, 1));
            r = 2'($urandom_range(1, 2));
            f = p ? $urandom_range(0, 2) : 0;
            run_txn(s, p, $urandom_range(0, 4), f, r);
            chk("rand_status", t_status, p ? int'(r) : 3);
            chk("rand_episodes", t_eps, f + 1);
            chk("rand_aq", t_aq_err, 0);
        end

        // Reset during BACKOFF.
        mdl_lat = 1; mdl_fails = 1000; mdl_res = 2'd1;
        issue_req(6'd33, 1'b1);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (waiting === 1'b1) found = 1; else cyc();
        end
        chk("rstbo_reach_backoff", found, 1);
        cyc();
        reset = 1'b1;
        cyc();
        chk("rstbo_outputs", {reqReady, respValid, respStatus, semSel, semAq, semRead, waiting}, 0);
        cyc();
        reset = 1'b0;
        cnt = 0;
        repeat (30) begin
            cyc();
            if (respValid === 1'b1 || semSel === 1'b1) cnt++;
        end
        chk("rstbo_no_resp", cnt, 0);
        chk("rstbo_ready", reqReady, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sem_waiter.md
# sem_waiter

Blocking-semaphore front end for one core. It accepts P (Wait) and V (Signal) requests from the core pipeline and drives the semaphore unit's `selLock`/`aq`/`read` local-I/O handshake. A failed P (`rq` = 0, ring Pfail) is retried automatically after a randomized exponential backoff, so software sees a single blocking call. The block sits directly upstream of the semaphore unit, between the core's I/O decode and that unit.

## Interface
Parameters:
- BACKOFF_MIN, 8: initial backoff window in cycles, power of two, ≥2.
- BACKOFF_MAX, 1024: window ceiling, power of two, ≥ BACKOFF_MIN, ≤ 2^15.
- MAX_TRIES, 0: P attempts before giving up; 0 = unlimited.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- whichCore  in  4  core number; seeds the jitter LFSR
- reqValid  in  1  core request present
- reqReady  out  1  block accepts a request this cycle
- reqSem  in  6  semaphore number
- reqWait  in  1  1 = P (Wait), 0 = V (Signal)
- abort  in  1  cancel a pending P during backoff
- respValid  out  1  one-cycle completion pulse
- respStatus  out  2  0 = gave up/aborted, 1 = acquired via ring, 2 = already held locally, 3 = V complete
- semSel  out  1  to semaphore unit `selLock`
- semAq  out  6  to semaphore unit `aq[8:3]`
- semRead  out  1  to semaphore unit `read` (1 = P)
- semRq  in  32  semaphore unit `rq`
- semWrq  in  1  semaphore unit `wrq`
- semDone  in  1  semaphore unit `done`
- waiting  out  1  high in BACKOFF (debug/perf counter)

## Operation
- States: IDLE, ISSUE, BACKOFF, RESP.
- IDLE: reqReady = 1. On reqValid, latch reqSem/reqWait, set tries = 0, window = BACKOFF_MIN, go to ISSUE.
- ISSUE: semSel = 1. semAq and semRead come from the latched values and are held stable until semDone. On semDone:
  - V: status 3, go to RESP.
  - P with semWrq and semRq[1:0] ∈ {1,2}: status = semRq[1:0], go to RESP.
  - P with semRq[1:0] = 0: tries += 1. If MAX_TRIES ≠ 0 and tries == MAX_TRIES, status 0, go to RESP. Otherwise load backoff = window + (lfsr[7:0] & (window−1) & 8'hFF), set window = min(2·window, BACKOFF_MAX), go to BACKOFF.
- BACKOFF: semSel = 0; counter decrements each cycle. At 1, go to ISSUE. If abort is sampled high, status 0 and go to RESP; abort takes priority over expiry.
- RESP: respValid = 1 with respStatus valid for exactly one cycle, then IDLE.
- abort is ignored in IDLE, ISSUE and RESP. A ring operation already in flight is never cancelled.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Reset value {4'hA, whichCore}, which is never zero. Steps every cycle.
- Widths: window is 16 bits; backoff counter is 16 bits; tries is 16 bits and saturates when MAX_TRIES = 0.

## Timing
- Reset values: state IDLE, reqReady 0 while reset is high and 1 after, respValid 0, respStatus 0, semSel 0, semAq 0, semRead 0, waiting 0.
- Accept happens at the edge where reqValid & reqReady.
- ISSUE starts on the next cycle.
- A semaphore held locally, or any locally-held V, completes in ISSUE in the same cycle because semDone is combinational. respValid follows 2 cycles after the accept edge.
- Ring P/V latency equals the semaphore unit's latency plus 1 cycle for RESP.
- Backoff length counts cycles with semSel = 0, from the cycle after semDone to the cycle before re-ISSUE.
- semSel deasserts on the cycle after semDone, so the unit never sees a stale select.
- reqReady is 0 in ISSUE, BACKOFF and RESP. No new request is queued.
- Reset mid-operation returns to IDLE with no response. The semaphore unit shares the same reset, so no ring state is orphaned.

## Structure
- Shared package holds:
  - semaphore rq encodings: SEM_FAIL = 0, SEM_GOT = 1, SEM_HELD = 2;
  - respStatus encodings, adding SEM_VDONE = 3;
  - the state enum.
- One sub-module, `lfsr8`: seed input, step enable, 8-bit output. It is reusable by the messenger for its own backoff.

## Test plan
- Local hold: P on sem 5 with the model returning semDone & semWrq and rq = 2 in the same cycle → respValid at accept+2, respStatus = 2, semSel high for exactly 1 cycle.
- Ring acquire: P on sem 12, model done after 9 cycles with rq = 1 → respStatus = 1, semAq = 12 stable throughout ISSUE, semRead = 1.
- Retry/backoff: model fails 3 times then returns 1, whichCore = 3 → three BACKOFF intervals within [8,15], [16,31], [32,63] cycles respectively, then respStatus = 1.
- Give-up: MAX_TRIES = 2, model always fails → exactly 2 semSel episodes, then respStatus = 0.
- Abort: abort asserted in cycle 3 of a backoff → respValid on the next cycle with status 0 and no further semSel. An abort asserted during ISSUE is ignored.
- V and reset: V on sem 63 → semRead = 0, respStatus = 3. Reset asserted during BACKOFF → all outputs return to their reset values on the next cycle and no respValid is produced.
